// File: rtl/wb_split_pkg.sv
// wb_split_pkg: shared FSM state, response constants and status-register layout for the macro bus splitter
package wb_split_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    localparam logic [31:0] ERR_DATA     = 32'hDEAD_BEEF;
    localparam logic [31:0] TO_DATA_BASE = 32'hBAD0_0000;

    localparam int STAT_CNT_LSB = 24;
    localparam int STAT_TO_LSB  = 16;
    localparam int STAT_ACT_LSB = 0;

    function automatic logic [31:0] stat_word(input logic [7:0] cnt, input logic [3:0] to_idx, input logic [15:0] act);
        return (32'(cnt) << STAT_CNT_LSB) | (32'(to_idx) << STAT_TO_LSB) | (32'(act) << STAT_ACT_LSB);
    endfunction

endpackage

// File: rtl/wb_macro_bus_splitter_if.sv
// wb_macro_bus_splitter_if: user-area Wishbone port, per-macro fan-out bus and status signals
interface wb_macro_bus_splitter_if #(
    parameter int NUM_SLAVES = 6
);
    logic                    wbs_cyc_i;
    logic                    wbs_stb_i;
    logic                    wbs_we_i;
    logic [3:0]              wbs_sel_i;
    logic [31:0]             wbs_adr_i;
    logic [31:0]             wbs_dat_i;
    logic                    wbs_ack_o;
    logic [31:0]             wbs_dat_o;
    logic [NUM_SLAVES-1:0]   active_i;
    logic [NUM_SLAVES-1:0]   s_cyc_o;
    logic [NUM_SLAVES-1:0]   s_stb_o;
    logic                    s_we_o;
    logic [3:0]              s_sel_o;
    logic [31:0]             s_adr_o;
    logic [31:0]             s_dat_o;
    logic [NUM_SLAVES-1:0]   s_ack_i;
    logic [32*NUM_SLAVES-1:0] s_dat_i;
    logic [7:0]              err_cnt_o;
    logic                    irq_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, active_i, s_ack_i, s_dat_i,
        output wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_cnt_o, irq_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, active_i, s_ack_i, s_dat_i,
        input  wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_cnt_o, irq_o
    );

endinterface

// File: rtl/wb_split_decode.sv
// wb_split_decode: address window decoder, upper address bits to {hit, macro index}
module wb_split_decode #(
    parameter int          NUM_SLAVES = 6,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          WIN_SHIFT  = 16
) (
    input  logic [31-WIN_SHIFT:0] adr_hi,
    output logic                  hit,
    output logic [3:0]            idx
);
    localparam logic [4:0] NS = 5'(NUM_SLAVES);

    // hit when the address lies in the user space and names an existing macro
    always_comb begin
        idx = adr_hi[3:0];
        hit = (adr_hi[31-WIN_SHIFT:4] == ADDR_BASE[31:WIN_SHIFT+4]) && ({1'b0, adr_hi[3:0]} < NS);
    end

endmodule

// File: rtl/wb_macro_bus_splitter.sv
// wb_macro_bus_splitter: Wishbone fan-out to test macros with timeout/error responses (optional status window: WB_SPLIT_STATUS_EN)
module wb_macro_bus_splitter
    import wb_split_pkg::*;
#(
    parameter int          NUM_SLAVES = 6,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          WIN_SHIFT  = 16,
    parameter int          TIMEOUT    = 255
) (
    input logic                    wb_clk_i,
    input logic                    wb_rst_i,
    wb_macro_bus_splitter_if.slave bus
);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t                state, state_n;
    logic                  hit, go, ack_sel, expired, ack_q, irq_q, we_q;
    logic [3:0]            idx_d, idx_q, sel_q;
    logic [7:0]            to_cnt, err_cnt, err_sat;
    logic [15:0]           act16;
    logic [31:0]           rdata, dat_q, adr_q, wdat_q;
    logic [NUM_SLAVES-1:0] stb_q;
`ifdef WB_SPLIT_STATUS_EN
    localparam logic [3:0] STAT_IDX = 4'(NUM_SLAVES);
    logic                  stat_d, stat_q, stat_we_q;
    logic [3:0]            last_to;
    assign stat_d = (bus.wbs_adr_i[31:WIN_SHIFT+4] == ADDR_BASE[31:WIN_SHIFT+4]) && (idx_d == STAT_IDX);
`endif

    wb_split_decode #(.NUM_SLAVES(NUM_SLAVES), .ADDR_BASE(ADDR_BASE), .WIN_SHIFT(WIN_SHIFT)) u_dec (
        .adr_hi (bus.wbs_adr_i[31:WIN_SHIFT]),
        .hit    (hit),
        .idx    (idx_d)
    );

    assign act16   = 16'(bus.active_i);
    assign go      = hit && act16[idx_d];
    assign expired = to_cnt == TO_LIM;
    assign err_sat = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;
    assign bus.s_cyc_o   = stb_q;
    assign bus.s_stb_o   = stb_q;
    assign bus.s_we_o    = we_q;
    assign bus.s_sel_o   = sel_q;
    assign bus.s_adr_o   = adr_q;
    assign bus.s_dat_o   = wdat_q;
    assign bus.err_cnt_o = err_cnt;
    assign bus.irq_o     = irq_q;

    // return path: only the latched macro's ack and data are ever looked at
    always_comb begin
        rdata   = '0;
        ack_sel = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == 4'(k)) begin
                rdata   = bus.s_dat_i[k*32 +: 32];
                ack_sel = bus.s_ack_i[k];
            end
        end
    end

    // state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_n;
    end

    // next state; a request seen while the previous ack is still out is left for the next cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.wbs_cyc_i && bus.wbs_stb_i && !ack_q) state_n = go ? REQ : ERR;
            REQ:     state_n = !bus.wbs_cyc_i ? IDLE : (ack_sel || expired) ? RESP : REQ;
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // request latching, strobes, timeout counting and the one-cycle ack/data response
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
            dat_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            idx_q   <= '0;
            to_cnt  <= '0;
            err_cnt <= '0;
`ifdef WB_SPLIT_STATUS_EN
            stat_q    <= 1'b0;
            stat_we_q <= 1'b0;
            last_to   <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            irq_q <= 1'b0;
            if (ack_q) dat_q <= '0;
            case (state)
                IDLE: begin
                    if (state_n == REQ) begin
                        adr_q  <= bus.wbs_adr_i;
                        wdat_q <= bus.wbs_dat_i;
                        we_q   <= bus.wbs_we_i;
                        sel_q  <= bus.wbs_sel_i;
                        idx_q  <= idx_d;
                        stb_q  <= NUM_SLAVES'(1) << idx_d;
                    end
`ifdef WB_SPLIT_STATUS_EN
                    if (state_n == ERR) begin
                        stat_q    <= stat_d;
                        stat_we_q <= bus.wbs_we_i;
                    end
`endif
                end
                REQ: begin
                    if (!bus.wbs_cyc_i) begin
                        stb_q  <= '0;
                        to_cnt <= '0;
                    end else if (ack_sel) begin
                        stb_q <= '0;
                        dat_q <= rdata;
                        ack_q <= 1'b1;
                    end else if (expired) begin
                        stb_q   <= '0;
                        dat_q   <= TO_DATA_BASE | 32'(idx_q);
                        err_cnt <= err_sat;
                        irq_q   <= 1'b1;
                        ack_q   <= 1'b1;
`ifdef WB_SPLIT_STATUS_EN
                        last_to <= idx_q;
`endif
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                RESP: to_cnt <= '0;
                ERR: begin
                    ack_q <= 1'b1;
`ifdef WB_SPLIT_STATUS_EN
                    dat_q   <= stat_q ? stat_word(err_cnt, last_to, act16) : ERR_DATA;
                    err_cnt <= stat_q ? (stat_we_q ? 8'd0 : err_cnt) : err_sat;
`else
                    dat_q   <= ERR_DATA;
                    err_cnt <= err_sat;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_macro_bus_splitter.sv
// tb_wb_macro_bus_splitter: randomized scoreboard bench for the macro bus splitter
module tb_wb_macro_bus_splitter;

    localparam int N = 6;

    typedef struct {
        logic [31:0] dat;
        logic [7:0]  cnt;
        logic        irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_macro_bus_splitter_if #(.NUM_SLAVES(N)) bus ();

    wb_macro_bus_splitter #(
        .NUM_SLAVES (N),
        .ADDR_BASE  (32'h3000_0000),
        .WIN_SHIFT  (16),
        .TIMEOUT    (255)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    exp_t       q[$];
    int         vec = 0;
    int         bad = 0;
    logic [7:0] m_err = 8'd0;
    logic [3:0] m_to = 4'd0;
    logic       prev_ack = 1'b0;

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every ack presented by the DUT is matched against the oldest expected response
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && prev_ack) chk("ack_single_cycle", {bus.wbs_ack_o, bus.wbs_dat_o}, 0);
        if (!rst && bus.irq_o && !bus.wbs_ack_o) chk("irq_without_ack", 1, 0);
        if (!rst && bus.wbs_ack_o) begin
            if (q.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                e = q.pop_front();
                chk("resp_data", bus.wbs_dat_o, e.dat);
                chk("resp_err_cnt", bus.err_cnt_o, e.cnt);
                chk("resp_irq", bus.irq_o, e.irq);
            end
        end
        prev_ack = !rst && bus.wbs_ack_o;
    end

    task automatic noise(input logic [3:0] idx);
        bus.s_ack_i = N'($urandom);
        bus.s_ack_i[idx] = 1'b0;
        for (int k = 0; k < N; k++) bus.s_dat_i[k*32 +: 32] = $urandom;
    endtask

    // one master access; lat<0 means the macro never acks, drop_at>=0 drops cyc that many cycles after the strobe
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] wd, input logic [3:0] sel,
                       input logic [31:0] rd, input int lat, input int drop_at);
        logic [3:0]   idx;
        logic [15:0]  a16;
        logic         base, mapped;
        logic [N-1:0] onehot;
        int           n;
        idx    = adr[19:16];
        a16    = 16'(bus.active_i);
        base   = adr[31:20] == 12'h300;
        mapped = base && (idx < N) && a16[idx];
        onehot = N'(1) << idx;
        if (mapped) begin
            if (drop_at < 0) begin
                if (lat < 0) begin
                    m_err = sat(m_err);
                    m_to  = idx;
                    q.push_back('{dat: 32'hBAD0_0000 | 32'(idx), cnt: m_err, irq: 1'b1});
                end else q.push_back('{dat: rd, cnt: m_err, irq: 1'b0});
            end
        end
`ifdef WB_SPLIT_STATUS_EN
        else if (base && idx == N) begin
            q.push_back('{dat: {m_err, 4'd0, m_to, a16}, cnt: we ? 8'd0 : m_err, irq: 1'b0});
            if (we) m_err = 8'd0;
        end
`endif
        else begin
            m_err = sat(m_err);
            q.push_back('{dat: 32'hDEAD_BEEF, cnt: m_err, irq: 1'b0});
        end
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wd;
        bus.wbs_sel_i = sel;
        @(negedge clk);
        if (!mapped) begin
            chk("err_no_ack_cycle1", bus.wbs_ack_o, 0);
            chk("err_no_strobe", {bus.s_cyc_o, bus.s_stb_o}, 0);
            @(negedge clk);
            chk("err_ack_cycle2", bus.wbs_ack_o, 1);
        end else begin
            chk("strobe_onehot", {bus.s_cyc_o, bus.s_stb_o}, {onehot, onehot});
            chk("req_regs", {bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o}, {we, sel, adr, wd});
            if (drop_at >= 0) begin
                repeat (drop_at) begin noise(idx); @(negedge clk); end
                bus.wbs_cyc_i = 1'b0;
                bus.wbs_stb_i = 1'b0;
                bus.s_ack_i   = '0;
                @(negedge clk);
                chk("drop_clears_strobe", {bus.s_cyc_o, bus.s_stb_o}, 0);
            end else begin
                n = (lat < 0) ? 255 : lat;
                repeat (n) begin noise(idx); @(negedge clk); end
                if (lat < 0) begin
                    bus.s_ack_i = '0;
                    chk("no_early_timeout", bus.wbs_ack_o, 0);
                    @(negedge clk);
                    chk("timeout_ack", bus.wbs_ack_o, 1);
                end else begin
                    noise(idx);
                    bus.s_ack_i[idx] = 1'b1;
                    bus.s_dat_i[idx*32 +: 32] = rd;
                    @(negedge clk);
                    chk("ack_latency", bus.wbs_ack_o, 1);
                end
            end
        end
        bus.s_ack_i = '0;
        if (bus.wbs_cyc_i) begin
            @(negedge clk);
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] adr;
        int          kind, lat, drop;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = '0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.active_i  = '1;
        bus.s_ack_i   = '0;
        bus.s_dat_i   = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {bus.wbs_ack_o, bus.irq_o, bus.err_cnt_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o}, 0);
        chk("reset_buses", {bus.wbs_dat_o, bus.s_adr_o, bus.s_dat_o}, 0);
        rst = 1'b0;

        txn(32'h3002_0000, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 2, -1);
        txn(32'h3000_0010, 1'b1, 32'hA5A5_A5A5, 4'b0011, 32'h0BAD_F00D, 1, -1);
        bus.active_i = 6'h37;
        txn(32'h3003_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, -1);
        bus.active_i = '1;
        txn(32'h3004_0000, 1'b0, 32'h0, 4'hF, 32'h0, -1, -1);
        txn(32'h3001_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, 2);
        txn(32'h3005_0000, 1'b0, 32'h0, 4'hF, 32'hCAFE_0005, 0, -1);
        txn(32'h3006_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, -1);
        txn(32'h4000_0000, 1'b1, 32'h1, 4'hF, 32'h0, 0, -1);

        for (int i = 0; i < 150; i++) begin
            bus.active_i = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            kind = $urandom_range(0, 9);
            adr  = $urandom;
            if (kind == 0) begin
                if (adr[31:20] == 12'h300) adr[31] = ~adr[31];
            end else if (kind == 1) adr[31:20] = 12'h300;
            else adr = {12'h300, 4'($urandom_range(0, N-1)), 16'($urandom)};
            lat  = ($urandom_range(0, 39) == 0) ? -1 : $urandom_range(0, 4);
            drop = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
            txn(adr, 1'($urandom), $urandom, 4'($urandom), $urandom, lat, drop);
        end
        bus.active_i = '1;

        repeat (300) txn(32'h5000_0000 | 32'($urandom_range(0, 65535)), 1'b0, 32'h0, 4'hF, 32'h0, 0, -1);
        chk("err_cnt_saturated", bus.err_cnt_o, 8'hFF);
`ifdef WB_SPLIT_STATUS_EN
        txn(32'h3006_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, -1);
        txn(32'h3006_0000, 1'b1, 32'h1234, 4'hF, 32'h0, 0, -1);
        chk("status_write_clears", bus.err_cnt_o, 8'd0);
`endif

        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = 32'h3000_0004;
        bus.wbs_dat_i = 32'h5555_AAAA;
        @(negedge clk);
        chk("mid_reset_strobe_up", bus.s_stb_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_ctrl", {bus.wbs_ack_o, bus.irq_o, bus.err_cnt_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}, 0);
        chk("mid_reset_buses", {bus.wbs_dat_o, bus.s_adr_o, bus.s_dat_o}, 0);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        rst   = 1'b0;
        m_err = 8'd0;
        m_to  = 4'd0;
        txn(32'h3003_0000, 1'b0, 32'h0, 4'hF, 32'h7777_0003, 3, -1);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 96'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/wb_macro_bus_splitter.md
Name: wb_macro_bus_splitter

Overview:
- Wishbone fan-out stage between the user-area Wishbone slave port (wbs_*) and the NUM_SLAVES test macros. Each macro gets a dedicated address window.
- Decodes the address, gates the macro's strobe by its LA-driven active bit, registers the request, and muxes ack/data back. Only one macro ever drives the return path.
- Unmapped or inactive addresses and hung macros get a deterministic error response, so the management core never stalls.

Parameters:
- NUM_SLAVES, 6, number of macro ports (1..15).
- ADDR_BASE, 32'h3000_0000, base of the user Wishbone space.
- WIN_SHIFT, 16, log2 of per-macro window size. Slave index = adr[WIN_SHIFT+3:WIN_SHIFT].
- TIMEOUT, 255, maximum cycles to wait for a slave ack (1..255).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master request.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  ack to master.
- wbs_dat_o  out  32  read data to master.
- active_i  in  NUM_SLAVES  per-macro enable (LA bits).
- s_cyc_o, s_stb_o  out  NUM_SLAVES  one-hot per-macro cycle/strobe.
- s_we_o  out  1  registered write enable.
- s_sel_o  out  4  registered byte selects.
- s_adr_o  out  32  registered address.
- s_dat_o  out  32  registered write data.
- s_ack_i  in  NUM_SLAVES  per-macro ack.
- s_dat_i  in  32*NUM_SLAVES  per-macro read data, slave k at [32k+31:32k].
- err_cnt_o  out  8  saturating count of error responses.
- irq_o  out  1  one-cycle pulse on each timeout.

Behaviour:
- Reset: FSM=IDLE. All outputs 0: s_cyc_o/s_stb_o, wbs_ack_o, wbs_dat_o, err_cnt_o, irq_o, and all s_* buses. Timeout counter 0.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE, when wbs_cyc_i & wbs_stb_i, decode:
  - adr[31:WIN_SHIFT+4] == ADDR_BASE[31:WIN_SHIFT+4], idx < NUM_SLAVES, and active_i[idx]=1: latch adr/dat/we/sel/idx, set s_cyc_o[idx]=s_stb_o[idx]=1 next cycle, go REQ.
  - Otherwise: go ERR.
- REQ:
  - s_ack_i[idx]=1: capture s_dat_i slice, clear strobes, go RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: clear strobes, load wbs_dat_o=32'hBAD0_0000|idx, err_cnt++, irq_o=1 for one cycle, go RESP.
  - s_ack_i bits of non-selected slaves are ignored.
- RESP: wbs_ack_o=1 for exactly one cycle, wbs_dat_o holds the captured data, counter cleared, go IDLE.
- ERR: wbs_ack_o=1 for one cycle, wbs_dat_o=32'hDEAD_BEEF, err_cnt++, go IDLE. irq_o is not asserted.
- wbs_dat_o returns to 0 in the cycle after the ack.
- err_cnt_o saturates at 8'hFF.
- IDLE ignores the request in the same cycle wbs_ack_o is high; the next request is sampled the following cycle.
- Latency: request sampled at cycle 0 → s_stb_o at cycle 1. Slave ack at cycle N → wbs_ack_o at N+1. Minimum total is 3 cycles.
- Unmapped/inactive access: wbs_ack_o at cycle 2.
- Master drops wbs_cyc_i in REQ: strobes clear next cycle, go IDLE, no ack, no error count.
- active_i[idx] falling during REQ does not abort the access; the timeout still applies.
- wb_rst_i asserted mid-transaction: everything returns to reset values on the next edge.

Optional Feature:
- WB_SPLIT_STATUS_EN defined: window index NUM_SLAVES is an internal status register.
  - Read returns {err_cnt[7:0], 4'd0, last_timeout_idx[3:0], active_i zero-extended to 16}.
  - Write of any value clears err_cnt.
  - Access follows the ERR timing path (ack at cycle 2) but is not counted as an error.
- Undefined: that window is unmapped and answers 32'hDEAD_BEEF.

Decomposition:
- Package wb_split_pkg holds:
  - FSM state typedef.
  - Constants ERR_DATA=32'hDEAD_BEEF and TO_DATA_BASE=32'hBAD0_0000.
  - Status-register field offsets.
- Sub-module wb_split_decode: combinational address→{hit, idx} decoder, reused by future multi-master arbitration.

Test Plan:
- Read 0x3002_0000, active_i=6'h3F, slave 2 acks 2 cycles after strobe with 32'h1234_5678 → s_stb_o=6'b000100, wbs_dat_o=32'h1234_5678, wbs_ack_o 1 cycle after s_ack_i.
- Write 0x3000_0010 data 32'hA5A5_A5A5 sel 4'b0011 → s_we_o=1, s_sel_o=4'b0011, s_dat_o=32'hA5A5_A5A5 on slave 0 only.
- Read 0x3003_0000 with active_i[3]=0 → no slave strobe, ack at cycle 2, data 32'hDEAD_BEEF, err_cnt_o 0→1.
- Slave 4 never acks, TIMEOUT=255 → ack 256 cycles after strobe, data 32'hBAD0_0004, irq_o one pulse, err_cnt_o +1.
- Master drops cyc 3 cycles into a slave-1 access → strobes clear next cycle, no ack, err_cnt_o unchanged.
- 300 unmapped accesses → err_cnt_o stays 8'hFF. With WB_SPLIT_STATUS_EN, write to 0x3006_0000 → err_cnt_o returns to 0.
